// File: rtl/benes_route_scheduler_if.sv
// Bundle between the route requesters and benes_route_scheduler.
// master: requester side (drives requests, observes grants/completions)
// slave : scheduler side
interface benes_route_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int SEL_W = 5
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*SEL_W-1:0] req_module_sel;
    logic [N_REQ*SEL_W-1:0] req_slot_sel;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       req_done;
    logic [N_REQ-1:0]       req_err;
    logic [SEL_W-1:0]       o_module_select;
    logic [SEL_W-1:0]       o_slot_select;
    logic                   o_cfg_load;
    logic                   o_busy;
    logic [GW-1:0]          o_grant_id;
    logic [31:0]            o_busy_cycles;

    modport master (
        output req_valid, req_module_sel, req_slot_sel,
        input  req_ready, req_done, req_err, o_module_select, o_slot_select,
               o_cfg_load, o_busy, o_grant_id, o_busy_cycles
    );

    modport slave (
        input  req_valid, req_module_sel, req_slot_sel,
        output req_ready, req_done, req_err, o_module_select, o_slot_select,
               o_cfg_load, o_busy, o_grant_id, o_busy_cycles
    );
endinterface

// File: rtl/benes_route_scheduler.sv
// benes_route_scheduler: round-robin arbiter that sequences one route at a
// time into the shared Benes interconnect (latch selects, load, wait for the
// network latency, then acknowledge the granted requester).
// Optional macro BENES_SCHED_PERF_EN adds a saturating busy-cycle counter.
//
// state | meaning
// IDLE  | round-robin pick, accept one request
// CFG   | selects presented with o_cfg_load strobe
// WAIT  | down-count the network latency
// DONE  | done (and err) pulse to the granted requester
module benes_route_scheduler #(
    parameter int N_REQ     = 4,
    parameter int NUM_SLOT  = 20,
    parameter int SEL_W     = 5,
    parameter int BENES_LAT = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    benes_route_scheduler_if.slave bus
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (BENES_LAT > 1) ? $clog2(BENES_LAT) : 1;

    typedef enum logic [1:0] {IDLE, CFG, WAIT, DONE} state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    ptr_q, ptr_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [SEL_W-1:0] mod_q, mod_d, slot_q, slot_d;
    logic             err_q, err_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             found;
    logic [GW-1:0]    pick;
    logic [GW:0]      rr_sum;
    logic [SEL_W-1:0] mod_arr  [N_REQ];
    logic [SEL_W-1:0] slot_arr [N_REQ];
    logic             pick_err;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign mod_arr[g]  = bus.req_module_sel[g*SEL_W +: SEL_W];
        assign slot_arr[g] = bus.req_slot_sel[g*SEL_W +: SEL_W];
    end

    // Round-robin search: first valid requester at or after the pointer
    always_comb begin
        found  = 1'b0;
        pick   = '0;
        rr_sum = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rr_sum = {1'b0, ptr_q} + (GW+1)'(k);
            if (rr_sum >= (GW+1)'(N_REQ)) begin
                rr_sum = rr_sum - (GW+1)'(N_REQ);
            end
            if (!found && bus.req_valid[rr_sum[GW-1:0]]) begin
                found = 1'b1;
                pick  = rr_sum[GW-1:0];
            end
        end
    end

    // Either select outside the routable range sends the request down the error path
    assign pick_err = ({1'b0, mod_arr[pick]}  >= (SEL_W+1)'(NUM_SLOT)) ||
                      ({1'b0, slot_arr[pick]} >= (SEL_W+1)'(NUM_SLOT));

    // Next-state and output decode
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        mod_d   = mod_q;
        slot_d  = slot_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        bus.req_ready  = '0;
        bus.req_done   = '0;
        bus.req_err    = '0;
        bus.o_cfg_load = 1'b0;
        bus.o_busy     = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (found) begin
                    bus.req_ready = N_REQ'(1) << pick;
                    grant_d = pick;
                    ptr_d   = (pick == GW'(N_REQ-1)) ? '0 : pick + GW'(1);
                    err_d   = pick_err;
                    if (pick_err) begin
                        state_d = DONE;
                    end else begin
                        // selects only change on a legal route, so an illegal request leaves them intact
                        mod_d   = mod_arr[pick];
                        slot_d  = slot_arr[pick];
                        state_d = CFG;
                    end
                end
            end
            CFG: begin
                bus.o_cfg_load = 1'b1;
                cnt_d   = CW'(BENES_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                bus.req_done = N_REQ'(1) << grant_q;
                bus.req_err  = err_q ? (N_REQ'(1) << grant_q) : '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            mod_q   <= '0;
            slot_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            mod_q   <= mod_d;
            slot_q  <= slot_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_module_select = mod_q;
    assign bus.o_slot_select   = slot_q;
    assign bus.o_grant_id      = grant_q;

`ifdef BENES_SCHED_PERF_EN
    logic [31:0] busy_cnt_q;

    // Saturating count of cycles spent outside IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt_q <= '0;
        end else if (state_q != IDLE && busy_cnt_q != 32'hFFFF_FFFF) begin
            busy_cnt_q <= busy_cnt_q + 32'd1;
        end
    end

    assign bus.o_busy_cycles = busy_cnt_q;
`else
    assign bus.o_busy_cycles = '0;
`endif
endmodule

// File: tb/tb_benes_route_scheduler.sv
// Self-checking bench for benes_route_scheduler: a small round-robin model
// predicts each grant; completions are queued and checked by a monitor.
module tb_benes_route_scheduler;
    localparam int N_REQ = 4, NUM_SLOT = 20, SEL_W = 5, BENES_LAT = 4;
`ifdef BENES_SCHED_PERF_EN
    localparam int PERF_D = 2 + BENES_LAT;
`else
    localparam int PERF_D = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    benes_route_scheduler_if #(.N_REQ(N_REQ), .SEL_W(SEL_W)) bus ();

    benes_route_scheduler #(
        .N_REQ(N_REQ), .NUM_SLOT(NUM_SLOT), .SEL_W(SEL_W), .BENES_LAT(BENES_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        int             id;
        bit             err;
        logic [SEL_W-1:0] m;
        logic [SEL_W-1:0] s;
        int             cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int errors = 0, checks = 0, cyc = 0;
    int pend[N_REQ];
    logic [SEL_W-1:0] pm[N_REQ], ps[N_REQ];
    int model_ptr = 0, free_cyc = 0, drop_id = -1;
    logic [SEL_W-1:0] last_m = '0, last_s = '0;
    int acc_cyc[$], acc_id[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive();
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_valid[i] = (pend[i] > 0) || (i == drop_id && cyc < free_cyc - 2);
            bus.req_module_sel[i*SEL_W +: SEL_W] = pm[i];
            bus.req_slot_sel[i*SEL_W +: SEL_W]   = ps[i];
        end
    endtask

    // Completion / load monitor, compares against the scoreboard front
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_cfg_load) begin
                checks++;
                if (sbq.size() == 0 || sbq[0].err) begin
                    errors++;
                    $display("FAIL cfg_load_unexpected at cyc %0d", cyc);
                end else begin
                    checks++;
                    if ({bus.o_module_select, bus.o_slot_select} !== {sbq[0].m, sbq[0].s}) begin
                        errors++;
                        $display("FAIL cfg_selects got %0d/%0d exp %0d/%0d", bus.o_module_select,
                                 bus.o_slot_select, sbq[0].m, sbq[0].s);
                    end
                    checks++;
                    if (cyc !== sbq[0].cyc - 1 - BENES_LAT) begin
                        errors++;
                        $display("FAIL cfg_time got %0d exp %0d", cyc, sbq[0].cyc - 1 - BENES_LAT);
                    end
                end
            end
            checks++;
            if ((bus.req_err & ~bus.req_done) !== '0) begin
                errors++;
                $display("FAIL err_without_done got err=%b done=%b", bus.req_err, bus.req_done);
            end
            if (bus.req_done !== '0) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected got %b at cyc %0d", bus.req_done, cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    checks++;
                    if (bus.req_done !== (N_REQ'(1) << mon_e.id)) begin
                        errors++;
                        $display("FAIL done_bit got %b exp id %0d", bus.req_done, mon_e.id);
                    end
                    checks++;
                    if (bus.req_err !== (mon_e.err ? (N_REQ'(1) << mon_e.id) : N_REQ'(0))) begin
                        errors++;
                        $display("FAIL err_bit got %b exp err=%0d id %0d", bus.req_err, mon_e.err, mon_e.id);
                    end
                    checks++;
                    if (cyc !== mon_e.cyc) begin
                        errors++;
                        $display("FAIL done_time got %0d exp %0d", cyc, mon_e.cyc);
                    end
                    checks++;
                    if (int'(bus.o_grant_id) !== mon_e.id) begin
                        errors++;
                        $display("FAIL grant_id got %0d exp %0d", bus.o_grant_id, mon_e.id);
                    end
                    if (mon_e.err) begin
                        checks++;
                        if ({bus.o_module_select, bus.o_slot_select} !== {last_m, last_s}) begin
                            errors++;
                            $display("FAIL err_selects_changed got %0d/%0d exp %0d/%0d",
                                     bus.o_module_select, bus.o_slot_select, last_m, last_s);
                        end
                    end else begin
                        last_m = mon_e.m;
                        last_s = mon_e.s;
                    end
                end
            end
        end
    end

    // Drive requests cycle by cycle and check req_ready against the RR model
    task automatic run_sched(input int maxc, input bit stop_on_acc);
        int n = 0;
        int pick;
        bit all_idle;
        bit e;
        logic [N_REQ-1:0] expr;
        while (n < maxc) begin
            @(posedge clk);
            #1 drive();
            @(negedge clk);
            n++;
            expr = '0;
            pick = -1;
            if (cyc >= free_cyc) begin
                for (int k = 0; k < N_REQ; k++) begin
                    int j = (model_ptr + k) % N_REQ;
                    if (pick < 0 && pend[j] > 0) pick = j;
                end
            end
            if (pick >= 0) expr = N_REQ'(1) << pick;
            if (expr != '0 || bus.req_ready != '0) begin
                checks++;
                if (bus.req_ready !== expr) begin
                    errors++;
                    $display("FAIL ready got %b exp %b at cyc %0d", bus.req_ready, expr, cyc);
                end
            end
            for (int k = 0; k < N_REQ; k++) begin
                if (bus.req_ready[k] === 1'b1) begin
                    acc_cyc.push_back(cyc);
                    acc_id.push_back(k);
                end
            end
            if (pick >= 0) begin
                e = (pm[pick] >= NUM_SLOT) || (ps[pick] >= NUM_SLOT);
                sbq.push_back('{id: pick, err: e, m: pm[pick], s: ps[pick],
                                cyc: cyc + (e ? 1 : 2 + BENES_LAT)});
                pend[pick]--;
                model_ptr = (pick + 1) % N_REQ;
                free_cyc = cyc + (e ? 2 : 3 + BENES_LAT);
                if (stop_on_acc) return;
            end
            all_idle = 1'b1;
            for (int k = 0; k < N_REQ; k++) if (pend[k] > 0) all_idle = 1'b0;
            if (all_idle && sbq.size() == 0) return;
        end
        errors++;
        $display("FAIL sched_timeout after %0d cycles", maxc);
    endtask

    task automatic test_reset();
        for (int i = 0; i < N_REQ; i++) begin
            pend[i] = 0; pm[i] = '0; ps[i] = '0;
        end
        drive();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.o_busy, bus.o_cfg_load, bus.req_done, bus.req_err, bus.req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got busy=%b cfg=%b done=%b err=%b rdy=%b", bus.o_busy,
                     bus.o_cfg_load, bus.req_done, bus.req_err, bus.req_ready);
        end
        checks++;
        if ({bus.o_module_select, bus.o_slot_select, bus.o_grant_id} !== '0) begin
            errors++;
            $display("FAIL reset_sel got %0d/%0d grant %0d", bus.o_module_select, bus.o_slot_select,
                     bus.o_grant_id);
        end
        checks++;
        if (bus.o_busy_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_busy_cycles got %0d exp 0", bus.o_busy_cycles);
        end
        rst_n = 1'b1;
        free_cyc = cyc;
        model_ptr = 0;
    endtask

    task automatic test_all_four();
        acc_cyc.delete(); acc_id.delete();
        for (int i = 0; i < N_REQ; i++) begin
            pend[i] = 1; pm[i] = SEL_W'(i + 1); ps[i] = SEL_W'(10 + i);
        end
        run_sched(60, 0);
        checks++;
        if (acc_id.size() !== 4) begin
            errors++;
            $display("FAIL all4_count got %0d exp 4", acc_id.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (acc_id[k] !== k) begin
                    errors++;
                    $display("FAIL all4_order slot %0d got %0d exp %0d", k, acc_id[k], k);
                end
                if (k > 0) begin
                    checks++;
                    if (acc_cyc[k] - acc_cyc[k-1] !== 3 + BENES_LAT) begin
                        errors++;
                        $display("FAIL all4_gap got %0d exp %0d", acc_cyc[k] - acc_cyc[k-1], 3 + BENES_LAT);
                    end
                end
            end
        end
    endtask

    task automatic test_rr_fair();
        int exp_rr[4] = '{0, 2, 0, 2};
        acc_id.delete();
        pend[0] = 2; pm[0] = 5'd6; ps[0] = 5'd1;
        pend[2] = 2; pm[2] = 5'd0; ps[2] = 5'd19;
        run_sched(60, 0);
        checks++;
        if (acc_id.size() !== 4) begin
            errors++;
            $display("FAIL rr_count got %0d exp 4", acc_id.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (acc_id[k] !== exp_rr[k]) begin
                    errors++;
                    $display("FAIL rr_order slot %0d got %0d exp %0d", k, acc_id[k], exp_rr[k]);
                end
            end
        end
    endtask

    task automatic test_single();
        pend[0] = 1; pm[0] = 5'd3; ps[0] = 5'd7;
        run_sched(30, 0);
    endtask

    task automatic test_illegal();
        pend[1] = 1; pm[1] = 5'd2; ps[1] = 5'd20;
        run_sched(20, 0);
        pend[1] = 1; pm[1] = 5'd31; ps[1] = 5'd0;
        run_sched(20, 0);
    endtask

    task automatic test_perf();
        logic [31:0] b0;
        b0 = bus.o_busy_cycles;
        pend[3] = 1; pm[3] = 5'd19; ps[3] = 5'd19;
        run_sched(30, 0);
        @(negedge clk);
        checks++;
        if (bus.o_busy_cycles !== b0 + 32'(PERF_D)) begin
            errors++;
            $display("FAIL busy_cycles got %0d exp %0d", bus.o_busy_cycles, b0 + 32'(PERF_D));
        end
    endtask

    task automatic test_valid_drop();
        drop_id = 3;
        pend[0] = 1; pm[0] = 5'd8; ps[0] = 5'd12;
        run_sched(30, 0);
        drop_id = -1;
        drive();
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== '0 || bus.o_busy !== 1'b0) begin
                errors++;
                $display("FAIL dropped_valid_grant got rdy=%b busy=%b", bus.req_ready, bus.o_busy);
            end
        end
    endtask

    task automatic test_reset_wait();
        int t;
        pend[1] = 1; pm[1] = 5'd5; ps[1] = 5'd9;
        run_sched(20, 1);
        t = acc_cyc[$];
        @(posedge clk);
        #1 drive();
        while (cyc < t + 3) @(negedge clk);
        checks++;
        if (bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_busy got %b exp 1", bus.o_busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_busy, bus.o_cfg_load, bus.o_module_select, bus.o_slot_select, bus.o_grant_id} !== '0) begin
            errors++;
            $display("FAIL async_reset got busy=%b sel=%0d/%0d grant=%0d", bus.o_busy,
                     bus.o_module_select, bus.o_slot_select, bus.o_grant_id);
        end
        sbq.delete();
        model_ptr = 0;
        last_m = '0; last_s = '0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (bus.req_done !== '0 || bus.req_err !== '0) begin
                errors++;
                $display("FAIL done_in_reset got done=%b err=%b", bus.req_done, bus.req_err);
            end
        end
        rst_n = 1'b1;
        free_cyc = cyc;
        pend[2] = 1; pm[2] = 5'd11; ps[2] = 5'd4;
        run_sched(30, 0);
    endtask

    initial begin
        test_reset();
        test_all_four();
        test_rr_fair();
        test_single();
        test_illegal();
        test_perf();
        test_valid_drop();
        test_reset_wait();
        repeat (2) @(negedge clk);
        checks++;
        if (sbq.size() !== 0) begin
            errors++;
            $display("FAIL leftover_expected got %0d exp 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached at cyc %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
